// File: rtl/imem_boot_loader.sv
// Instruction memory with a byte-stream boot loader: fills the memory from a
// length-prefixed little-endian stream, then releases the core and serves fetches.
module imem_boot_loader #(
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC,
   output logic [31:0] ins,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        load_err,
   output logic        pc_misalign
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_LOAD, S_RUN, S_ERR} state_t;

   state_t      state, state_d;
   logic [16:0] n_words, wcnt, wcnt_inc, hdr_n;
   logic [1:0]  bidx;
   logic [23:0] hold;
   logic        accept, word_we;
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LEN0;
      else        state <= state_d;
   end

   always_comb begin
      state_d    = state;
      byte_ready = 1'b0;
      hdr_n      = {1'b0, byte_data, n_words[7:0]};
      wcnt_inc   = wcnt + 17'd1;
      case (state)
         S_LEN0: begin
            byte_ready = 1'b1;
            if (byte_valid) state_d = S_LEN1;
         end
         S_LEN1: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (hdr_n > 17'(DEPTH))  state_d = S_ERR;
               else if (hdr_n == '0)    state_d = S_RUN;
               else                     state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            if (byte_valid && bidx == 2'd3 && wcnt_inc == n_words) state_d = S_RUN;
         end
         default: ;
      endcase
      accept  = byte_valid && byte_ready;
      word_we = accept && (state == S_LOAD) && (bidx == 2'd3);
   end

   // Status outputs lag the state by one edge so they never see byte_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_words    <= '0;
         wcnt       <= '0;
         bidx       <= '0;
         hold       <= '0;
         core_rst_n <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         core_rst_n <= (state == S_RUN);
         load_done  <= (state == S_RUN);
         load_err   <= (state == S_ERR);
         if (accept) begin
            case (state)
               S_LEN0: n_words <= {9'd0, byte_data};
               S_LEN1: n_words <= hdr_n;
               S_LOAD: begin
                  hold <= {byte_data, hold[23:8]};
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) wcnt <= wcnt_inc;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (word_we) mem[wcnt[AW-1:0]] <= {byte_data, hold};
   end

   // n_words never exceeds DEPTH, so the bound check also covers high PC bits.
   always_comb begin
      ins = NOP_INSN;
      if (state == S_RUN && PC[31:2] < {13'd0, n_words}) ins = mem[PC[AW+1:2]];
      pc_misalign = |PC[1:0];
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios, a fetch table,
// and randomized streams checked against a byte-queue reference model.
module tb_imem_boot_loader;

   localparam int          D   = 1024;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, ins;
   logic        byte_valid, byte_ready, core_rst_n, load_done, load_err, pc_misalign;
   logic [7:0]  byte_data;
   logic [31:0] pc16, ins16;
   logic        v16, ready16, core16, done16, err16, mis16;
   logic [7:0]  d16;

   int checks = 0;
   int errors = 0;
   logic [7:0] acc[$];

   always #5 clk = ~clk;

   imem_boot_loader #(.DEPTH(D), .NOP_INSN(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .PC(pc), .ins(ins), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .core_rst_n(core_rst_n),
      .load_done(load_done), .load_err(load_err), .pc_misalign(pc_misalign));

   imem_boot_loader #(.DEPTH(16), .NOP_INSN(NOP)) dut16 (
      .clk(clk), .rst_n(rst_n), .PC(pc16), .ins(ins16), .byte_valid(v16),
      .byte_data(d16), .byte_ready(ready16), .core_rst_n(core16),
      .load_done(done16), .load_err(err16), .pc_misalign(mis16));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: everything derives from the bytes accepted since reset.
   function automatic bit m_hdr();
      return acc.size() >= 2;
   endfunction
   function automatic int m_n();
      return m_hdr() ? int'({acc[1], acc[0]}) : 0;
   endfunction
   function automatic bit m_err();
      return m_hdr() && m_n() > D;
   endfunction
   function automatic bit m_loaded();
      return m_hdr() && !m_err() && acc.size() == 2 + 4 * m_n();
   endfunction
   function automatic bit m_ready();
      return !m_err() && !m_loaded();
   endfunction
   function automatic logic [31:0] m_ins(input logic [31:0] a);
      int unsigned w;
      int b;
      w = a[31:2];
      if (!m_loaded() || w >= int'(m_n())) return NOP;
      b = 2 + 4 * int'(w);
      return {acc[b+3], acc[b+2], acc[b+1], acc[b]};
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return r;
         1:       return {20'd0, r[11:0]};
         default: return {26'd0, r[5:2], 2'b00};
      endcase
   endfunction

   // One clock of the main DUT with full model comparison.
   task automatic cyc(input bit v, input logic [7:0] d);
      bit was_loaded, was_err;
      byte_valid = v;
      byte_data  = d;
      pc         = rand_pc();
      was_loaded = m_loaded();
      was_err    = m_err();
      #1;
      chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_ready()});
      if (v && m_ready()) acc.push_back(d);
      @(posedge clk); #1;
      chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, was_loaded});
      chk("load_done",  {31'd0, load_done},  {31'd0, was_loaded});
      chk("load_err",   {31'd0, load_err},   {31'd0, was_err});
      chk("ins",        ins, m_ins(pc));
      chk("pc_misalign", {31'd0, pc_misalign}, {31'd0, |pc[1:0]});
   endtask

   task automatic do_reset();
      byte_valid = 1'b0;
      v16        = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      acc.delete();
      chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
      chk("rst_load_done",  {31'd0, load_done},  32'd0);
      chk("rst_load_err",   {31'd0, load_err},   32'd0);
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send16(input logic [7:0] d);
      v16 = 1'b1;
      d16 = d;
      #1;
      chk("ready16", {31'd0, ready16}, 32'd1);
      @(posedge clk); #1;
      v16 = 1'b0;
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        mis;
   } fetch_vec_t;

   fetch_vec_t tbl[8];
   logic [7:0] s10[10];

   task automatic run_table();
      for (int i = 0; i < 8; i++) begin
         pc = tbl[i].pc;
         #1;
         chk("tbl_ins", ins, tbl[i].ins);
         chk("tbl_mis", {31'd0, pc_misalign}, {31'd0, tbl[i].mis});
      end
   endtask

   initial begin
      tbl[0] = '{32'h00000000, 32'h00500513, 1'b0};
      tbl[1] = '{32'h00000004, 32'h00300593, 1'b0};
      tbl[2] = '{32'h00000008, NOP,          1'b0};
      tbl[3] = '{32'h00000002, 32'h00500513, 1'b1};
      tbl[4] = '{32'h00000007, 32'h00300593, 1'b1};
      tbl[5] = '{32'h00001000, NOP,          1'b0};
      tbl[6] = '{32'hFFFFFFFC, NOP,          1'b0};
      tbl[7] = '{32'h00001004, NOP,          1'b0};
      s10 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};

      rst_n = 1'b1; byte_valid = 1'b0; byte_data = '0; pc = '0;
      v16 = 1'b0; d16 = '0; pc16 = '0;

      // Basic 2-word load.
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, s10[i]);
      cyc(1'b0, 8'h00);
      chk("run_core_rst_n", {31'd0, core_rst_n}, 32'd1);
      run_table();

      // Same stream with a 5-cycle valid gap between image bytes 2 and 3.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i == 5) for (int g = 0; g < 5; g++) cyc(1'b0, 8'hAA);
         cyc(1'b1, s10[i]);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF);
      run_table();

      // Empty image.
      do_reset();
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h00);
      chk("empty_core_early", {31'd0, core_rst_n}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h13);
      pc = 32'h0; #1;
      chk("empty_ins0", ins, NOP);
      chk("empty_core", {31'd0, core_rst_n}, 32'd1);

      // Reset after 6 bytes, then a full reload.
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, s10[i]);
      do_reset();
      pc = 32'h0; #1;
      chk("reload_ins0_pre", ins, NOP);
      for (int i = 0; i < 10; i++) cyc(1'b1, s10[i]);
      cyc(1'b0, 8'h00);
      run_table();

      // DEPTH=16: oversize header locks into error.
      do_reset();
      send16(8'h11);
      send16(8'h00);
      @(posedge clk); #1;
      for (int i = 0; i < 100; i++) begin
         v16 = 1'b1; d16 = 8'($urandom); pc16 = $urandom;
         #1;
         chk("err16_err",   {31'd0, err16},   32'd1);
         chk("err16_ready", {31'd0, ready16}, 32'd0);
         chk("err16_core",  {31'd0, core16},  32'd0);
         chk("err16_ins",   ins16, NOP);
         @(posedge clk); #1;
      end
      v16 = 1'b0;

      // DEPTH=16: full-depth image (N == DEPTH is legal).
      do_reset();
      send16(8'h10);
      send16(8'h00);
      for (int w = 0; w < 16; w++) begin
         logic [31:0] word;
         word = 32'h1000_0000 + 32'(w) * 32'h0001_0203;
         for (int b = 0; b < 4; b++) send16(word[8*b +: 8]);
      end
      @(posedge clk); #1;
      chk("full16_done", {31'd0, done16}, 32'd1);
      chk("full16_err",  {31'd0, err16},  32'd0);
      for (int w = 0; w < 16; w++) begin
         pc16 = 32'(w) * 4; #1;
         chk("full16_ins", ins16, 32'h1000_0000 + 32'(w) * 32'h0001_0203);
      end
      pc16 = 32'd64; #1;
      chk("full16_oob", ins16, NOP);

      // Randomized streams against the model.
      for (int it = 0; it < 40; it++) begin
         logic [7:0] s[$];
         int n, idx, limit;
         bit aborted;
         case ($urandom_range(0, 9))
            0:       n = (it == 7) ? D : D + 1 + int'($urandom_range(0, 64000));
            1:       n = 0;
            default: n = int'($urandom_range(1, 6));
         endcase
         s.delete();
         s.push_back(8'(n));
         s.push_back(8'(n >> 8));
         if (n <= D) for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
         do_reset();
         idx = 0;
         limit = 3 * s.size() + 50;
         aborted = 1'b0;
         for (int c = 0; c < limit && idx < s.size(); c++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            if (n < D && $urandom_range(0, 199) == 0) begin
               aborted = 1'b1;
               break;
            end
            if (v && m_ready()) begin
               cyc(1'b1, s[idx]);
               idx++;
            end else begin
               cyc(v, 8'($urandom));
               if (v && !m_ready()) idx = s.size();
            end
         end
         if (!aborted && idx < s.size()) chk("rand_timeout", 32'(idx), 32'(s.size()));
         for (int k = 0; k < 4; k++) cyc($urandom_range(0, 1) == 1, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
